// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller drives the master side; the datapath holds the slave side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences each instruction
// over 3-5 cycles and drives every datapath select and write enable.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.master bus,
  output logic [3:0]            state,
  output logic [CNT_W-1:0]      fetch_cnt
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == FETCH) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Moore outputs; unreachable codes fall to the all-zero default.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_op        = 2'b00;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write      = 1'b1;
        pc_update     = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_write     = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        mem_write  = 1'b1;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = 2'b10;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op      = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pc_update   = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.ALUControl = 3'b000;
    case (alu_op)
      2'b00: bus.ALUControl = 3'b000;
      2'b01: bus.ALUControl = 3'b001;
      default: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.ALUControl = 3'b101;
          3'b100:  bus.ALUControl = 3'b100;
          3'b110:  bus.ALUControl = 3'b011;
          3'b111:  bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    bus.ImmSrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Reset holds state at FETCH, so the write enables must be gated explicitly.
  assign bus.PCWrite  = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite  = ~reset & ir_write;
  assign bus.MemWrite = ~reset & mem_write;
  assign bus.RegWrite = ~reset & reg_write;

  assign state     = state_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random
// instruction streams compared against an instruction-level reference model.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state;
  logic [3:0] fetch_cnt;
  logic [3:0] cnt_model;
  int         checks = 0;
  int         passed = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .state     (state),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Expected state visited at step i of an instruction, -1 once it has completed.
  function automatic int path_state(logic [6:0] o, int i);
    int seq[5];
    int len;
    seq = '{0, 1, 0, 0, 0};
    len = 2;
    case (o)
      LW: begin seq = '{0, 1, 2, 3, 4};  len = 5; end
      SW: begin seq = '{0, 1, 2, 5, 0};  len = 4; end
      RT: begin seq = '{0, 1, 6, 8, 0};  len = 4; end
      IT: begin seq = '{0, 1, 7, 8, 0};  len = 4; end
      JL: begin seq = '{0, 1, 10, 8, 0}; len = 4; end
      BQ: begin seq = '{0, 1, 9, 0, 0};  len = 3; end
      default: len = 2;
    endcase
    return (i < len) ? seq[i] : -1;
  endfunction

  // Expected control word by the role each state plays in the instruction.
  function automatic logic [15:0] model_ctrl(int st, logic [6:0] o, logic [2:0] f3,
                                             logic f7, logic z);
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, srca, srcb, imm;
    logic [2:0] alu;
    pcw  = (st == 0) || (st == 10) || (st == 9 && z);
    adr  = (st == 3) || (st == 5);
    memw = (st == 5);
    irw  = (st == 0);
    regw = (st == 4) || (st == 8);
    res  = (st == 0) ? 2'b10 : (st == 4) ? 2'b01 : 2'b00;
    srca = (st == 1 || st == 10) ? 2'b01 :
           (st == 2 || st == 6 || st == 7 || st == 9) ? 2'b10 : 2'b00;
    srcb = (st == 0 || st == 10) ? 2'b10 :
           (st == 1 || st == 2 || st == 7) ? 2'b01 : 2'b00;
    imm  = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    alu  = 3'b000;
    if (st == 9) alu = 3'b001;
    if (st == 6 || st == 7) begin
      case (f3)
        3'b000:  alu = (o == RT && f7) ? 3'b001 : 3'b000;
        3'b010:  alu = 3'b101;
        3'b100:  alu = 3'b100;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    return {pcw, adr, memw, irw, res, srca, srcb, regw, imm, alu};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state);
      else passed++;
      checks++;
      if (fetch_cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt);
      else passed++;
      checks++;
      if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000)
        $display("FAIL reset_enables got=%b exp=0000",
                 {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
      else passed++;
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    cnt_model = '0;
  endtask

  task automatic test_directed();
    logic [11:0] tab [13];
    logic [6:0]  o;
    logic [2:0]  f3;
    logic        f7, z;
    int          es;
    tab = '{{LW, 3'b000, 1'b0, 1'b0}, {SW, 3'b010, 1'b0, 1'b0},
            {RT, 3'b000, 1'b1, 1'b0}, {IT, 3'b000, 1'b1, 1'b0},
            {IT, 3'b100, 1'b0, 1'b0}, {BQ, 3'b000, 1'b0, 1'b1},
            {BQ, 3'b000, 1'b0, 1'b0}, {JL, 3'b000, 1'b0, 1'b0},
            {7'b0000000, 3'b000, 1'b0, 1'b0}, {RT, 3'b111, 1'b0, 1'b1},
            {RT, 3'b010, 1'b0, 1'b0}, {IT, 3'b110, 1'b1, 1'b0},
            {RT, 3'b011, 1'b1, 1'b0}};
    for (int k = 0; k < 13; k++) begin
      {o, f3, f7, z} = tab[k];
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
      for (int i = 0; path_state(o, i) >= 0; i++) begin
        es = path_state(o, i);
        bus.Zero = (es == 9) ? z : 1'($urandom);
        @(negedge clk);
        checks++;
        if (state !== 4'(es))
          $display("FAIL dir_state k=%0d step=%0d got=%0d exp=%0d", k, i, state, es);
        else passed++;
        checks++;
        if (obs_ctrl() !== model_ctrl(es, o, f3, f7, bus.Zero))
          $display("FAIL dir_ctrl k=%0d step=%0d got=%b exp=%b", k, i, obs_ctrl(),
                   model_ctrl(es, o, f3, f7, bus.Zero));
        else passed++;
        checks++;
        if (fetch_cnt !== cnt_model)
          $display("FAIL dir_cnt k=%0d step=%0d got=%0d exp=%0d", k, i, fetch_cnt, cnt_model);
        else passed++;
        if (es == 0) cnt_model = cnt_model + 4'd1;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    int         es;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BQ;
        5: o = JL;
        default: o = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
      for (int i = 0; path_state(o, i) >= 0; i++) begin
        es = path_state(o, i);
        bus.Zero = 1'($urandom);
        @(negedge clk);
        checks++;
        if (state !== 4'(es))
          $display("FAIL rnd_state op=%b step=%0d got=%0d exp=%0d", o, i, state, es);
        else passed++;
        checks++;
        if (obs_ctrl() !== model_ctrl(es, o, f3, f7, bus.Zero))
          $display("FAIL rnd_ctrl op=%b f3=%b step=%0d got=%b exp=%b", o, f3, i, obs_ctrl(),
                   model_ctrl(es, o, f3, f7, bus.Zero));
        else passed++;
        checks++;
        if (fetch_cnt !== cnt_model)
          $display("FAIL rnd_cnt op=%b step=%0d got=%0d exp=%0d", o, i, fetch_cnt, cnt_model);
        else passed++;
        if (es == 0) cnt_model = cnt_model + 4'd1;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_midinstr();
    bus.op = SW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd5 || bus.MemWrite !== 1'b1)
      $display("FAIL mid_pre got_state=%0d got_memwrite=%b exp=5/1", state, bus.MemWrite);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) $display("FAIL mid_async_state got=%0d exp=0", state);
    else passed++;
    checks++;
    if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000)
      $display("FAIL mid_enables got=%b exp=0000",
               {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
    else passed++;
    checks++;
    if (fetch_cnt !== 4'd0) $display("FAIL mid_cnt got=%0d exp=0", fetch_cnt);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || fetch_cnt !== 4'd0 || bus.MemWrite !== 1'b0)
      $display("FAIL mid_hold got_state=%0d got_cnt=%0d got_mw=%b exp=0/0/0",
               state, fetch_cnt, bus.MemWrite);
    else passed++;
    reset = 1'b0;
    cnt_model = '0;
  endtask

  task automatic test_fetch_wrap();
    bus.op = 7'b0000000;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || fetch_cnt !== 4'(k))
        $display("FAIL wrap_fetch k=%0d got_state=%0d got_cnt=%0d exp=0/%0d",
                 k, state, fetch_cnt, 4'(k));
      else passed++;
      @(negedge clk);
      checks++;
      if (state !== 4'd1) $display("FAIL wrap_decode k=%0d got=%0d exp=1", k, state);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || fetch_cnt !== 4'd1)
      $display("FAIL wrap_end got_state=%0d got_cnt=%0d exp=0/1", state, fetch_cnt);
    else passed++;
  endtask

  initial begin
    cnt_model = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_midinstr();
    test_fetch_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
